// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding and timing defaults for the VGA sync receiver
//
// Purpose : receiver FSM state type, default 640x480 (800x525 total) timing
//           constants, counter saturation value and an active-window helper.
// Ports   : none (package).
package vga_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } vga_state_t;

  localparam int H_TOTAL_DEF     = 800;
  localparam int V_TOTAL_DEF     = 525;
  localparam int H_ACT_OFS_DEF   = 144;
  localparam int H_ACT_DEF       = 640;
  localparam int V_ACT_OFS_DEF   = 35;
  localparam int V_ACT_DEF       = 480;
  localparam int LOCK_FRAMES_DEF = 2;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  // True when counter value c lies in [ofs, ofs+len).
  function automatic logic in_window(input logic [9:0] c, input int ofs, input int len);
    int v;
    v = int'({22'd0, c});
    return (v >= ofs) && (v < (ofs + len));
  endfunction

endpackage

// File: rtl/vga_sync_rx_if.sv
// rtl/vga_sync_rx_if.sv - sync input and decoded timing output bundle
//
// Purpose : groups the pixel strobe, sync inputs and all decoded outputs.
// Ports   : slave modport = receiver side (syncs in, timing out);
//           master modport = source/observer side.
interface vga_sync_rx_if;
  logic       i_pix_stb;
  logic       i_hs;
  logic       i_vs;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_active;
  logic       o_locked;
  logic       o_frame_start;
  logic       o_err;
  logic [9:0] o_line_len;
  logic [9:0] o_frame_lines;

  modport slave (
    input  i_pix_stb, i_hs, i_vs,
    output o_x, o_y, o_active, o_locked, o_frame_start, o_err,
           o_line_len, o_frame_lines
  );

  modport master (
    output i_pix_stb, i_hs, i_vs,
    input  o_x, o_y, o_active, o_locked, o_frame_start, o_err,
           o_line_len, o_frame_lines
  );
endinterface

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - strobe-qualified falling-edge detector for an active-low sync
//
// Purpose : samples i_sig on strobe cycles; o_edge is high on the strobe where
//           the previous sample was 1 and the current input is 0.
// Ports   : i_clk, i_rst_n (async active-low), i_stb (pixel strobe),
//           i_sig (sync input), o_edge (combinational leading-edge flag).
module vga_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_sig,
  output logic o_edge
);

  logic r_prev;

  // Idle-high after reset so a sync already low is seen as a leading edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
    end else if (i_stb) begin
      r_prev <= i_sig;
    end
  end

  assign o_edge = i_stb & r_prev & ~i_sig;

endmodule

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA HS/VS timing receiver with lock detection and active-area decode
//
// Purpose : measures line length and frame height from active-low HS/VS,
//           locks after LOCK_FRAMES consecutive matching frames and produces
//           active-area x/y coordinates while locked.
// Ports   : i_clk, i_rst_n (async active-low);
//           bus (slave): i_pix_stb, i_hs, i_vs in; o_x, o_y, o_active,
//           o_locked, o_frame_start, o_err, o_line_len, o_frame_lines out.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int H_ACT_OFS   = H_ACT_OFS_DEF,
  parameter int H_ACT       = H_ACT_DEF,
  parameter int V_ACT_OFS   = V_ACT_OFS_DEF,
  parameter int V_ACT       = V_ACT_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  vga_sync_rx_if.slave  bus
);

  logic       w_hs_edge;
  logic       w_vs_edge;

  vga_state_t r_state;
  vga_state_t w_state_d;
  logic [2:0] r_match;
  logic [2:0] w_match_d;
  logic [3:0] w_match_inc;
  logic       w_store_ref;
  logic       w_err_evt;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic [9:0] w_meas_len;
  logic [9:0] w_meas_lines;
  logic [9:0] r_ref_len;
  logic [9:0] r_ref_lines;
  logic       w_active;

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_active;
  logic       r_locked;
  logic       r_frame_start;
  logic       r_err;
  logic [9:0] r_line_len;
  logic [9:0] r_frame_lines;

  vga_edge_det u_hs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (bus.i_pix_stb),
    .i_sig   (bus.i_hs),
    .o_edge  (w_hs_edge)
  );

  vga_edge_det u_vs_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (bus.i_pix_stb),
    .i_sig   (bus.i_vs),
    .o_edge  (w_vs_edge)
  );

  // Counter next values; edges are already strobe-qualified.
  always_comb begin
    w_h_nxt = r_h_cnt;
    if (w_hs_edge) begin
      w_h_nxt = 10'd0;
    end else if (bus.i_pix_stb && (r_h_cnt != CNT_MAX)) begin
      w_h_nxt = r_h_cnt + 10'd1;
    end

    w_v_nxt = r_v_cnt;
    if (w_vs_edge) begin
      w_v_nxt = 10'd0;
    end else if (w_hs_edge) begin
      w_v_nxt = r_v_cnt + 10'd1;
    end

    // A VS edge normally coincides with an HS edge, so the line just closed
    // is used rather than the previously latched length.
    w_meas_len   = w_hs_edge ? (r_h_cnt + 10'd1) : r_line_len;
    w_meas_lines = r_v_cnt + 10'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_SEARCH;
      r_match <= 3'd0;
    end else begin
      r_state <= w_state_d;
      r_match <= w_match_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_match_d   = r_match;
    w_store_ref = 1'b0;
    w_err_evt   = 1'b0;
    w_match_inc = {1'b0, r_match} + 4'd1;

    if (bus.i_pix_stb) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_vs_edge) begin
            w_state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_vs_edge) begin
            w_store_ref = 1'b1;
            w_match_d   = 3'd0;
            w_state_d   = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_vs_edge) begin
            if ((w_meas_len == r_ref_len) && (w_meas_lines == r_ref_lines)) begin
              w_match_d = w_match_inc[2:0];
              if (w_match_inc >= 4'(LOCK_FRAMES)) begin
                w_state_d = ST_LOCKED;
              end
            end else begin
              w_store_ref = 1'b1;
              w_match_d   = 3'd0;
            end
          end
        end
        ST_LOCKED: begin
          if ((w_hs_edge && (w_meas_len != r_ref_len)) ||
              (w_vs_edge && (w_meas_lines != r_ref_lines))) begin
            w_err_evt = 1'b1;
            w_state_d = ST_SEARCH;
          end
        end
        default: w_state_d = ST_SEARCH;
      endcase

      // Sync timeout: a line that runs into counter saturation drops lock
      // from any tracking state.
      if ((r_state != ST_SEARCH) && (w_h_nxt == CNT_MAX)) begin
        w_err_evt = 1'b1;
        w_state_d = ST_SEARCH;
      end
    end
  end

  // Decode against the post-strobe counters and state so outputs line up
  // with the counter values they describe.
  assign w_active = (w_state_d == ST_LOCKED) &&
                    in_window(w_h_nxt, H_ACT_OFS, H_ACT) &&
                    in_window(w_v_nxt, V_ACT_OFS, V_ACT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt       <= 10'd0;
      r_v_cnt       <= 10'd0;
      r_ref_len     <= 10'd0;
      r_ref_lines   <= 10'd0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_active      <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
      r_line_len    <= 10'd0;
      r_frame_lines <= 10'd0;
    end else begin
      // Pulses self-clear on the next clock, strobe or not.
      r_err         <= w_err_evt;
      r_frame_start <= w_vs_edge;
      if (bus.i_pix_stb) begin
        r_h_cnt  <= w_h_nxt;
        r_v_cnt  <= w_v_nxt;
        r_active <= w_active;
        r_locked <= (w_state_d == ST_LOCKED);
        r_x      <= w_active ? (w_h_nxt - 10'(H_ACT_OFS)) : 10'd0;
        r_y      <= w_active ? (w_v_nxt - 10'(V_ACT_OFS)) : 10'd0;
        if (w_hs_edge) begin
          r_line_len <= w_meas_len;
        end
        if (w_vs_edge) begin
          r_frame_lines <= w_meas_lines;
        end
        if (w_store_ref) begin
          r_ref_len   <= w_meas_len;
          r_ref_lines <= w_meas_lines;
        end
      end
    end
  end

  assign bus.o_x           = r_x;
  assign bus.o_y           = r_y;
  assign bus.o_active      = r_active;
  assign bus.o_locked      = r_locked;
  assign bus.o_frame_start = r_frame_start;
  assign bus.o_err         = r_err;
  assign bus.o_line_len    = r_line_len;
  assign bus.o_frame_lines = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed self-checking bench for vga_sync_rx on a scaled 40x12 timing
module tb_vga_sync_rx;

  localparam int LL    = 40;
  localparam int FL    = 12;
  localparam int HSW   = 4;
  localparam int VSW   = 2;
  localparam int H_OFS = 8;
  localparam int H_ACT = 24;
  localparam int V_OFS = 3;
  localparam int V_ACT = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_sync_rx_if bus();

  vga_sync_rx #(
    .H_ACT_OFS   (H_OFS),
    .H_ACT       (H_ACT),
    .V_ACT_OFS   (V_OFS),
    .V_ACT       (V_ACT),
    .LOCK_FRAMES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Called at a negedge; returns at the negedge after the strobe edge.
  task automatic pix(input logic hs, input logic vs, input int gap);
    repeat (gap) @(negedge clk);
    bus.i_hs      = hs;
    bus.i_vs      = vs;
    bus.i_pix_stb = 1'b1;
    @(negedge clk);
    bus.i_pix_stb = 1'b0;
  endtask

  task automatic frame_px(input int line, input int px, input int gap);
    pix(logic'(px >= HSW), logic'(line >= VSW), gap);
  endtask

  task automatic send_frames(input int n, input int gap);
    for (int f = 0; f < n; f++)
      for (int l = 0; l < FL; l++)
        for (int p = 0; p < LL; p++)
          frame_px(l, p, gap);
  endtask

  task automatic do_reset();
    bus.i_pix_stb = 1'b0;
    bus.i_hs      = 1'b1;
    bus.i_vs      = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Ends just after the 4th VS edge (frame 4, line 0, pixel 0).
  task automatic lock_up(input int gap);
    do_reset();
    send_frames(3, gap);
    frame_px(0, 0, gap);
  endtask

  // Continue from frame line 0 pixel 1 up to (but excluding) line stop_l pixel stop_p.
  task automatic run_to(input int stop_l, input int stop_p);
    for (int l = 0; l <= stop_l; l++)
      for (int p = (l == 0) ? 1 : 0; p < ((l == stop_l) ? stop_p : LL); p++)
        frame_px(l, p, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_x, bus.o_y, bus.o_active, bus.o_locked, bus.o_frame_start, bus.o_err} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d act=%0b lock=%0b fs=%0b err=%0b required all 0",
               bus.o_x, bus.o_y, bus.o_active, bus.o_locked, bus.o_frame_start, bus.o_err);
    end
    checks++;
    if ({bus.o_line_len, bus.o_frame_lines} !== 20'd0) begin
      errors++;
      $display("FAIL reset_measure: line_len=%0d frame_lines=%0d required 0 0", bus.o_line_len, bus.o_frame_lines);
    end
    do_reset();
  endtask

  task automatic test_lock(input int gap);
    do_reset();
    send_frames(3, gap);
    checks++;
    if (bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_before_edge4 gap=%0d: o_locked=%0b required 0", gap, bus.o_locked);
    end
    checks++;
    if (bus.o_frame_lines !== 10'd12) begin
      errors++;
      $display("FAIL frame_lines_edge3 gap=%0d: %0d required 12", gap, bus.o_frame_lines);
    end
    frame_px(0, 0, gap);
    checks++;
    if (bus.o_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_at_edge4 gap=%0d: o_locked=%0b required 1", gap, bus.o_locked);
    end
    checks++;
    if (bus.o_frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_pulse gap=%0d: %0b required 1", gap, bus.o_frame_start);
    end
    checks++;
    if (bus.o_line_len !== 10'd40 || bus.o_frame_lines !== 10'd12) begin
      errors++;
      $display("FAIL measured gap=%0d: line_len=%0d frame_lines=%0d required 40 12",
               gap, bus.o_line_len, bus.o_frame_lines);
    end
    @(negedge clk);
    checks++;
    if (bus.o_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL frame_start_clear gap=%0d: %0b required 0", gap, bus.o_frame_start);
    end
  endtask

  task automatic test_active();
    int act_cnt;
    act_cnt = 0;
    lock_up(0);
    for (int l = 0; l < FL; l++) begin
      for (int p = (l == 0) ? 1 : 0; p < LL; p++) begin
        frame_px(l, p, 0);
        if (bus.o_active === 1'b1) act_cnt++;
        if (l == V_OFS && p == H_OFS) begin
          checks++;
          if (bus.o_active !== 1'b1 || bus.o_x !== 10'd0 || bus.o_y !== 10'd0) begin
            errors++;
            $display("FAIL first_active: act=%0b x=%0d y=%0d required 1 0 0", bus.o_active, bus.o_x, bus.o_y);
          end
        end
        if (l == V_OFS + V_ACT - 1 && p == H_OFS + H_ACT - 1) begin
          checks++;
          if (bus.o_active !== 1'b1 || bus.o_x !== 10'(H_ACT - 1) || bus.o_y !== 10'(V_ACT - 1)) begin
            errors++;
            $display("FAIL last_active: act=%0b x=%0d y=%0d required 1 %0d %0d",
                     bus.o_active, bus.o_x, bus.o_y, H_ACT - 1, V_ACT - 1);
          end
        end
        if (l == V_OFS && p == H_OFS - 1) begin
          checks++;
          if (bus.o_active !== 1'b0 || bus.o_x !== 10'd0) begin
            errors++;
            $display("FAIL before_window: act=%0b x=%0d required 0 0", bus.o_active, bus.o_x);
          end
        end
        if (l == V_OFS + V_ACT && p == H_OFS) begin
          checks++;
          if (bus.o_active !== 1'b0 || bus.o_y !== 10'd0) begin
            errors++;
            $display("FAIL below_window: act=%0b y=%0d required 0 0", bus.o_active, bus.o_y);
          end
        end
      end
    end
    checks++;
    if (act_cnt != H_ACT * V_ACT) begin
      errors++;
      $display("FAIL active_count: %0d required %0d", act_cnt, H_ACT * V_ACT);
    end
    frame_px(0, 0, 0);
    checks++;
    if (bus.o_locked !== 1'b1 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL stay_locked: lock=%0b err=%0b required 1 0", bus.o_locked, bus.o_err);
    end
  endtask

  task automatic test_short_line();
    lock_up(0);
    run_to(5, LL - 1);
    frame_px(6, 0, 0);
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL short_line_err: err=%0b lock=%0b required 1 0", bus.o_err, bus.o_locked);
    end
    @(negedge clk);
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL short_line_pulse: err=%0b lock=%0b required 0 0", bus.o_err, bus.o_locked);
    end
  endtask

  task automatic test_timeout();
    int n;
    int n_err;
    lock_up(0);
    run_to(5, 0);
    frame_px(5, 0, 0);
    n = 0;
    n_err = 0;
    while (n < 1100 && n_err == 0) begin
      pix(1'b1, 1'b1, 0);
      n++;
      if (bus.o_err === 1'b1) n_err = n;
    end
    checks++;
    if (n_err != 1023) begin
      errors++;
      $display("FAIL timeout_point: err after %0d strobes required 1023", n_err);
    end
    checks++;
    if (bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_unlock: o_locked=%0b required 0", bus.o_locked);
    end
  endtask

  task automatic test_reset_mid();
    lock_up(0);
    run_to(4, 13);
    checks++;
    if (bus.o_active !== 1'b1 || bus.o_x !== 10'd4 || bus.o_y !== 10'd1) begin
      errors++;
      $display("FAIL pre_reset_active: act=%0b x=%0d y=%0d required 1 4 1", bus.o_active, bus.o_x, bus.o_y);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_x, bus.o_y, bus.o_active, bus.o_locked, bus.o_line_len, bus.o_frame_lines} !== 42'd0) begin
      errors++;
      $display("FAIL mid_reset: x=%0d y=%0d act=%0b lock=%0b len=%0d lines=%0d required all 0",
               bus.o_x, bus.o_y, bus.o_active, bus.o_locked, bus.o_line_len, bus.o_frame_lines);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frames(3, 0);
    checks++;
    if (bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_early: o_locked=%0b required 0", bus.o_locked);
    end
    frame_px(0, 0, 0);
    checks++;
    if (bus.o_locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_edge4: o_locked=%0b required 1", bus.o_locked);
    end
  endtask

  initial begin
    bus.i_pix_stb = 1'b0;
    bus.i_hs      = 1'b1;
    bus.i_vs      = 1'b1;
    test_reset();
    test_lock(0);
    test_active();
    test_short_line();
    test_timeout();
    test_reset_mid();
    test_lock(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
